// File: rtl/opt_reg_fifo.sv
// opt_reg_fifo: ready/valid FIFO feeding the single-cycle data register stage.
// Outputs depend only on registered state; res reads as zero while empty.
module opt_reg_fifo #(
    parameter int DataWidth = 16,
    parameter int Depth     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DataWidth-1:0]     data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DataWidth-1:0]     res,
    output logic [$clog2(Depth):0]   count
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_push;
    logic                 w_pop;

    always_comb begin
        in_ready  = r_count != CW'(Depth);
        out_valid = r_count != '0;
        res       = out_valid ? r_mem[r_rd_ptr] : '0;
        count     = r_count;
        w_push    = in_valid & in_ready;
        w_pop     = out_valid & out_ready;
    end

    // Storage is deliberately left out of reset; pointers alone define contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_opt_reg_fifo.sv
// tb_opt_reg_fifo: directed plan plus random traffic against a queue-based model.
module tb_opt_reg_fifo;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [DW-1:0] data_in = '0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [DW-1:0] res;
    logic [2:0]    count;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] q[$];

    opt_reg_fifo #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_cnt"}, 32'(count), 32'(q.size()));
        check({tag, "_ir"}, 32'(in_ready), 32'(q.size() != DEPTH));
        check({tag, "_ov"}, 32'(out_valid), 32'(q.size() != 0));
        check({tag, "_res"}, 32'(res), q.size() != 0 ? 32'(q[0]) : 32'h0);
    endtask

    task automatic step(input string tag);
        bit push, pop;
        @(posedge clk);
        if (!rst_n) q.delete();
        else begin
            push = in_valid && q.size() != DEPTH;
            pop  = out_ready && q.size() != 0;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(data_in);
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        rst_n = 0; in_valid = 1; data_in = 16'hAAAA;
        repeat (2) step("reset");
        check("reset_cnt0", 32'(count), 0);
        check("reset_res0", 32'(res), 0);
        rst_n = 1; in_valid = 1; data_in = 16'h1234; out_ready = 0;
        step("single_push");
        check("single_res", 32'(res), 32'h1234);
        in_valid = 0; out_ready = 1;
        step("single_pop");
        check("single_empty_res", 32'(res), 0);
        out_ready = 0; in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            data_in = DW'(i);
            step("fill");
        end
        check("full_cnt", 32'(count), 4);
        check("full_ir", 32'(in_ready), 0);
        data_in = 16'd5;
        repeat (2) step("overflow");
        in_valid = 0; out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(res), 32'(i));
            step("drain");
        end
        out_ready = 0; in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            data_in = DW'(i);
            step("refill");
        end
        data_in = 16'd9; out_ready = 1;
        step("full_pop_offer");
        check("full_pop_cnt", 32'(count), 3);
        out_ready = 0;
        check("full_pop_ir", 32'(in_ready), 1);
        step("accept9");
        in_valid = 0; out_ready = 1;
        repeat (4) step("drain2");
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            data_in = DW'(i);
            step("stream");
            check("stream_res", 32'(res), 32'(i));
            check("stream_cnt", 32'(count), 1);
        end
        in_valid = 0;
        step("stream_end");
        out_ready = 0; in_valid = 1;
        for (int i = 7; i <= 9; i++) begin
            data_in = DW'(i);
            step("burst");
        end
        rst_n = 0;
        step("midreset");
        check("midreset_ov", 32'(out_valid), 0);
        rst_n = 1; data_in = 16'h00FF;
        step("post_reset_push");
        check("post_reset_res", 32'(res), 32'h00FF);
        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            data_in   = DW'($urandom);
            rst_n     = $urandom_range(0, 199) != 0;
            step("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
